tag_ram_init_ctrl: RTL

// Initiator side of the L1.5 tag RAM port (req/write/addr/wdata -> rdata): sits between the

---
 rtl/tag_ram_init_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/tag_ram_init_ctrl.sv
// Tag bank front-end: sweeps FLUSH_VALUE into every entry after reset and on flush request,
// otherwise forwards controller lookups to the bank and returns read data with a valid strobe.
module tag_ram_init_ctrl #(
  parameter int                    DATA_WIDTH  = 10,
  parameter int                    ADDR_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req_i,
  output logic                  flush_ack_o,
  output logic                  busy_o,
  input  logic                  lookup_req_i,
  input  logic                  lookup_we_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  input  logic [DATA_WIDTH-1:0] lookup_wdata_i,
  output logic                  lookup_gnt_o,
  output logic                  lookup_rvalid_o,
  output logic [DATA_WIDTH-1:0] lookup_rdata_o,
  output logic                  tag_req_o,
  output logic                  tag_write_o,
  output logic [ADDR_WIDTH-1:0] tag_addr_o,
  output logic [DATA_WIDTH-1:0] tag_wdata_o,
  input  logic [DATA_WIDTH-1:0] tag_rdata_i
);

  typedef enum logic {SWEEP, IDLE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = '1;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   cnt_reg;
  logic                    ack_pend_reg;
  logic                    rvalid_reg;
  logic                    flush_ack_reg;

  logic sweeping;
  logic gnt;

  assign sweeping = (state_reg == SWEEP);
  // A flush taken in IDLE wins over a same-cycle lookup.
  assign gnt      = !rst && !sweeping && !flush_req_i && lookup_req_i;

  always_comb begin
    tag_req_o   = 1'b0;
    tag_write_o = 1'b0;
    tag_addr_o  = '0;
    tag_wdata_o = '0;
    if (!rst) begin
      if (sweeping) begin
        tag_req_o   = 1'b1;
        tag_write_o = 1'b1;
        tag_addr_o  = cnt_reg;
        tag_wdata_o = FLUSH_VALUE;
      end else if (!flush_req_i) begin
        tag_req_o   = lookup_req_i;
        tag_write_o = lookup_we_i;
        tag_addr_o  = lookup_addr_i;
        tag_wdata_o = lookup_wdata_i;
      end
    end
  end

  assign lookup_gnt_o    = gnt;
  assign busy_o          = rst || sweeping;
  assign flush_ack_o     = !rst && flush_ack_reg;
  assign lookup_rvalid_o = !rst && rvalid_reg;
  assign lookup_rdata_o  = lookup_rvalid_o ? tag_rdata_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SWEEP;
      cnt_reg       <= '0;
      ack_pend_reg  <= 1'b0;
      rvalid_reg    <= 1'b0;
      flush_ack_reg <= 1'b0;
    end else begin
      flush_ack_reg <= 1'b0;
      rvalid_reg    <= gnt && !lookup_we_i;
      case (state_reg)
        SWEEP: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (flush_req_i) ack_pend_reg <= 1'b1;
          if (cnt_reg == LAST_ENTRY) begin
            // A request seen on the final write is still covered by this sweep.
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            flush_ack_reg <= ack_pend_reg || flush_req_i;
            ack_pend_reg  <= 1'b0;
          end
        end
        IDLE: begin
          if (flush_req_i) begin
            state_reg    <= SWEEP;
            cnt_reg      <= '0;
            ack_pend_reg <= 1'b1;
          end
        end
        default: state_reg <= SWEEP;
      endcase
    end
  end

endmodule
